// File: rtl/cp0_pkg.sv
// ============================================================================
// Module      : cp0_pkg
// Description : Shared constants and packing helpers for the CP0 responder.
//               Register numbers, exception codes, and field positions of the
//               Status and Cause registers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cp0_pkg;

  // CP0 register numbers (rd field of mfc0/mtc0)
  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS  = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;

  // Cause.ExcCode values
  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;

  // Status field positions
  localparam int STATUS_IE_BIT  = 0;
  localparam int STATUS_EXL_BIT = 1;
  localparam int IM_LSB         = 7;
  localparam int IM_MSB         = 10;

  // Cause field positions
  localparam int IP_LSB  = 7;
  localparam int IP_MSB  = 10;
  localparam int EXC_LSB = 2;
  localparam int EXC_MSB = 6;

  // Interrupt source counts: IP[7] is the timer, IP[10:8] are irq[2:0]
  localparam int N_IRQ = 3;
  localparam int IP_W  = IP_MSB - IP_LSB + 1;

  // Assemble the architectural view of Status; unimplemented bits read 0
  function automatic logic [31:0] pack_status(input logic [IP_W-1:0] im,
                                              input logic            exl,
                                              input logic            ie);
    logic [31:0] r;
    r                 = '0;
    r[IM_MSB:IM_LSB]  = im;
    r[STATUS_EXL_BIT] = exl;
    r[STATUS_IE_BIT]  = ie;
    return r;
  endfunction

  // Assemble the architectural view of Cause; unimplemented bits read 0
  function automatic logic [31:0] pack_cause(input logic [IP_W-1:0] ip,
                                             input logic [4:0]      exc_code);
    logic [31:0] r;
    r                   = '0;
    r[IP_MSB:IP_LSB]    = ip;
    r[EXC_MSB:EXC_LSB]  = exc_code;
    return r;
  endfunction

endpackage : cp0_pkg

`default_nettype wire

// File: rtl/cp0_timer.sv
// ============================================================================
// Module      : cp0_timer
// Description : Count/Compare pair. Count increments every cycle and wraps;
//               a software load replaces the increment for that cycle.
//               match flags Count==Compare while Compare is non-zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cp0_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        match
);

  // Count runs free; a load takes priority over the increment
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (count_we) begin
      count <= wdata;
    end else begin
      count <= count + 32'd1;
    end
  end

  // Compare changes only on a software write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      compare <= '0;
    end else if (compare_we) begin
      compare <= wdata;
    end
  end

  // A zero Compare disables the timer so reset state never raises IP[7]
  assign match = (count == compare) && (compare != '0);

endmodule : cp0_timer

`default_nettype wire

// File: rtl/cp0_unit.sv
// ============================================================================
// Module      : cp0_unit
// Description : Coprocessor-0 responder for the single-cycle MIPS core.
//               Holds Status, Cause, EPC (and Count/Compare via cp0_timer),
//               and arbitrates syscall, interrupts and ERET into a single
//               same-cycle PC redirect.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0180
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_valid,
  input  logic        mfc0,
  input  logic        mtc0,
  input  logic        exce_ret,
  input  logic        sys,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc_cur,
  input  logic [N_IRQ-1:0] irq,
  output logic [31:0] rdata,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        exl,
  output logic        ie
);

  // Architectural state outside the timer
  logic [IP_W-1:0]  im;
  logic [IP_W-1:0]  ip;
  logic [4:0]       exc_code;
  logic [31:0]      epc;
  logic [N_IRQ-1:0] irq_q;

  // Timer interface
  logic [31:0] count;
  logic [31:0] compare;
  logic        timer_match;

  // Arbitration results
  logic active;
  logic int_pending;
  logic take_sys;
  logic take_int;
  logic take_eret;
  logic do_mtc0;

  // Individual register write enables for an accepted mtc0
  logic wr_status;
  logic wr_cause;
  logic wr_epc;
  logic wr_count;
  logic wr_compare;

  // Interrupt-pending update terms
  logic [IP_W-1:0] ip_set;
  logic [IP_W-1:0] ip_clr;
  logic [IP_W-1:0] ip_next;

  // The mfc0 strobe is qualified by the write-back mux, not here
  logic unused_mfc0;
  assign unused_mfc0 = mfc0;

  // --------------------------------------------------------------------------
  // Count / Compare
  // --------------------------------------------------------------------------
  cp0_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .count_we   (wr_count),
    .compare_we (wr_compare),
    .wdata      (wdata),
    .count      (count),
    .compare    (compare),
    .match      (timer_match)
  );

  // --------------------------------------------------------------------------
  // Arbitration: sys > interrupt > eret > mtc0. A reset cycle swallows every
  // strobe so no redirect escapes while state is being cleared.
  // --------------------------------------------------------------------------
  assign active      = inst_valid & rst_n;
  assign int_pending = ie & ~exl & (|(ip & im));

  assign take_sys  = active & sys;
  assign take_int  = active & ~sys & int_pending;
  assign take_eret = active & ~sys & ~int_pending & exce_ret;
  assign do_mtc0   = active & ~sys & ~int_pending & ~exce_ret & mtc0;

  assign wr_status  = do_mtc0 & (cp0_addr == CP0_STATUS);
  assign wr_cause   = do_mtc0 & (cp0_addr == CP0_CAUSE);
  assign wr_epc     = do_mtc0 & (cp0_addr == CP0_EPC);
  assign wr_count   = do_mtc0 & (cp0_addr == CP0_COUNT);
  assign wr_compare = do_mtc0 & (cp0_addr == CP0_COMPARE);

  // Fetch redirect: ERET returns to EPC, everything else goes to the vector
  assign redirect    = take_sys | take_int | take_eret;
  assign redirect_pc = take_eret ? epc : HANDLER_ADDR;
  assign flush       = take_sys | take_int;

  // --------------------------------------------------------------------------
  // Interrupt pending bits: sticky, set wins over a same-cycle clear.
  // IP[7] is the timer; IP[8+n] latches a rising edge of irq[n].
  // --------------------------------------------------------------------------
  assign ip_set[0] = timer_match;

  generate
    for (genvar n = 0; n < N_IRQ; n++) begin : g_irq_edge
      assign ip_set[n+1] = irq[n] & ~irq_q[n];
    end
  endgenerate

  // Cause writes are write-1-to-clear; a Compare write acknowledges the timer
  assign ip_clr  = (wr_cause ? wdata[IP_MSB:IP_LSB] : '0)
                 | {{(IP_W-1){1'b0}}, wr_compare};
  assign ip_next = (ip & ~ip_clr) | ip_set;

  // Edge-detect register and IP bits update every cycle, bubble or not
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_q <= '0;
      ip    <= '0;
    end else begin
      irq_q <= irq;
      ip    <= ip_next;
    end
  end

  // --------------------------------------------------------------------------
  // Status / ExcCode / EPC updates following the arbitration order
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      exc_code <= '0;
      epc      <= '0;
    end else if (take_sys) begin
      // A nested syscall must not lose the original return address
      if (!exl) begin
        epc <= pc_cur;
      end
      exc_code <= EXC_SYS;
      exl      <= 1'b1;
    end else if (take_int) begin
      // The interrupted instruction is flushed and re-executes after ERET
      epc      <= pc_cur;
      exc_code <= EXC_INT;
      exl      <= 1'b1;
    end else if (take_eret) begin
      exl <= 1'b0;
    end else if (wr_status) begin
      im  <= wdata[IM_MSB:IM_LSB];
      exl <= wdata[STATUS_EXL_BIT];
      ie  <= wdata[STATUS_IE_BIT];
    end else if (wr_epc) begin
      epc <= wdata;
    end
  end

  // --------------------------------------------------------------------------
  // mfc0 read mux: combinational, shows pre-edge state
  // --------------------------------------------------------------------------
  always_comb begin
    rdata = '0;
    case (cp0_addr)
      CP0_COUNT:   rdata = count;
      CP0_COMPARE: rdata = compare;
      CP0_STATUS:  rdata = pack_status(im, exl, ie);
      CP0_CAUSE:   rdata = pack_cause(ip, exc_code);
      CP0_EPC:     rdata = epc;
      default:     rdata = '0;
    endcase
  end

endmodule : cp0_unit

`default_nettype wire

// File: tb/tb_cp0_unit.sv
// ============================================================================
// Module      : tb_cp0_unit
// Description : Self-checking bench for cp0_unit. Each cycle's expected
//               outputs are queued when the stimulus is driven and drained
//               against the DUT at the following falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cp0_unit;

  localparam logic [31:0] HANDLER = 32'h0000_0180;

  localparam int K_RDATA = 0;
  localparam int K_REDIR = 1;
  localparam int K_RPC   = 2;
  localparam int K_FLUSH = 3;
  localparam int K_EXL   = 4;
  localparam int K_IE    = 5;

  localparam logic [4:0] A_COUNT   = 5'd9;
  localparam logic [4:0] A_COMPARE = 5'd11;
  localparam logic [4:0] A_STATUS  = 5'd12;
  localparam logic [4:0] A_CAUSE   = 5'd13;
  localparam logic [4:0] A_EPC     = 5'd14;

  logic        clk;
  logic        rst_n;
  logic        inst_valid;
  logic        mfc0;
  logic        mtc0;
  logic        exce_ret;
  logic        sys;
  logic [4:0]  cp0_addr;
  logic [31:0] wdata;
  logic [31:0] pc_cur;
  logic [2:0]  irq;
  logic [31:0] rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        exl;
  logic        ie;

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks;
  int   n_fail;

  cp0_unit #(.HANDLER_ADDR(HANDLER)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .inst_valid  (inst_valid),
    .mfc0        (mfc0),
    .mtc0        (mtc0),
    .exce_ret    (exce_ret),
    .sys         (sys),
    .cp0_addr    (cp0_addr),
    .wdata       (wdata),
    .pc_cur      (pc_cur),
    .irq         (irq),
    .rdata       (rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .flush       (flush),
    .exl         (exl),
    .ie          (ie)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act,
                          input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int kind);
    case (kind)
      K_RDATA: return rdata;
      K_REDIR: return {31'b0, redirect};
      K_RPC:   return redirect_pc;
      K_FLUSH: return {31'b0, flush};
      K_EXL:   return {31'b0, exl};
      K_IE:    return {31'b0, ie};
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic expect_out(input string tag, input int kind,
                            input logic [31:0] exp);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  // Drain this cycle's expectations mid-cycle, then advance past the edge
  task automatic step();
    exp_t e;
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq(e.tag, observe(e.kind), e.exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic mt, input logic er,
                       input logic sy, input logic [4:0] addr,
                       input logic [31:0] wd, input logic [31:0] pc);
    inst_valid = v;
    mfc0       = 1'b0;
    mtc0       = mt;
    exce_ret   = er;
    sys        = sy;
    cp0_addr   = addr;
    wdata      = wd;
    pc_cur     = pc;
  endtask

  // Bubble cycle with the read mux pointed at addr
  task automatic rd(input logic [4:0] addr);
    drive(1'b0, 1'b0, 1'b0, 1'b0, addr, 32'h0, 32'h0);
    mfc0 = 1'b1;
  endtask

  task automatic expect_redirect(input string tag, input logic r,
                                 input logic [31:0] pc, input logic f);
    expect_out({tag, "_redir"}, K_REDIR, {31'b0, r});
    if (r) expect_out({tag, "_rpc"}, K_RPC, pc);
    expect_out({tag, "_flush"}, K_FLUSH, {31'b0, f});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    irq      = 3'b000;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    @(posedge clk);
    #1;

    // Reset dominates a valid syscall
    drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0, 32'h40);
    expect_redirect("rst_sys", 1'b0, 32'h0, 1'b0);
    step();
    rst_n = 1'b1;

    rd(A_COUNT);  expect_out("rst_count", K_RDATA, 32'h0);
    expect_out("rst_exl", K_EXL, 32'h0);
    expect_out("rst_ie", K_IE, 32'h0);
    expect_redirect("rst_idle", 1'b0, 32'h0, 1'b0);
    step();
    rd(A_STATUS); expect_out("rst_status", K_RDATA, 32'h0); step();
    rd(A_CAUSE);  expect_out("rst_cause", K_RDATA, 32'h0);  step();
    rd(A_EPC);    expect_out("rst_epc", K_RDATA, 32'h0);    step();

    // Syscall
    drive(1'b1, 1'b1, 1'b0, 1'b0, A_STATUS, 32'h0, 32'h10);
    expect_redirect("mtc0_st0", 1'b0, 32'h0, 1'b0);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0, 32'h40);
    expect_redirect("sys", 1'b1, HANDLER, 1'b1);
    step();
    rd(A_EPC);    expect_out("sys_epc", K_RDATA, 32'h40);   step();
    rd(A_CAUSE);  expect_out("sys_cause", K_RDATA, 32'h20); step();
    rd(A_STATUS); expect_out("sys_status", K_RDATA, 32'h2);
    expect_out("sys_exl", K_EXL, 32'h1);
    step();

    // External interrupt on irq[2]
    drive(1'b1, 1'b1, 1'b0, 1'b0, A_STATUS, 32'h401, 32'h44);
    expect_redirect("mtc0_st401", 1'b0, 32'h0, 1'b0);
    step();
    rd(A_CAUSE); irq = 3'b100;
    expect_out("irq_pre_ip", K_RDATA, 32'h20);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, A_CAUSE, 32'h0, 32'h88);
    expect_out("irq_ip10", K_RDATA, 32'h420);
    expect_redirect("irq_take", 1'b1, HANDLER, 1'b1);
    step();
    rd(A_EPC);   expect_out("irq_epc", K_RDATA, 32'h88);
    expect_out("irq_exl", K_EXL, 32'h1);
    step();
    rd(A_CAUSE); expect_out("irq_cause", K_RDATA, 32'h400); step();

    // W1C clear, then ERET: no re-entry
    drive(1'b1, 1'b1, 1'b0, 1'b0, A_CAUSE, 32'h400, 32'h180);
    expect_redirect("w1c", 1'b0, 32'h0, 1'b0);
    step();
    rd(A_CAUSE); expect_out("w1c_cause", K_RDATA, 32'h0); step();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 32'h184);
    expect_redirect("eret1", 1'b1, 32'h88, 1'b0);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h88);
    expect_redirect("no_reentry", 1'b0, 32'h0, 1'b0);
    expect_out("eret1_exl", K_EXL, 32'h0);
    step();

    // Re-entry when IP is left pending
    rd(5'd0); irq = 3'b000; step();
    rd(5'd0); irq = 3'b100; step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h88);
    expect_redirect("irq2_take", 1'b1, HANDLER, 1'b1);
    step();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 32'h180);
    expect_redirect("eret2", 1'b1, 32'h88, 1'b0);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h88);
    expect_redirect("retake", 1'b1, HANDLER, 1'b1);
    step();

    // sys with EXL=1 keeps EPC
    drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0, 32'h200);
    expect_redirect("sys_exl1", 1'b1, HANDLER, 1'b1);
    step();
    rd(A_EPC);   expect_out("sys_exl1_epc", K_RDATA, 32'h88);    step();
    rd(A_CAUSE); expect_out("sys_exl1_cause", K_RDATA, 32'h420); step();

    // sys beats a pending enabled interrupt
    drive(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 32'h204);
    expect_redirect("eret3", 1'b1, 32'h88, 1'b0);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0, 32'h300);
    expect_redirect("sys_vs_int", 1'b1, HANDLER, 1'b1);
    step();
    rd(A_CAUSE); expect_out("sys_vs_int_cause", K_RDATA, 32'h420); step();
    rd(A_EPC);   expect_out("sys_vs_int_epc", K_RDATA, 32'h300);   step();

    // Interrupt drops a same-cycle mtc0 EPC
    drive(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 32'h304);
    expect_redirect("eret4", 1'b1, 32'h300, 1'b0);
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b0, A_EPC, 32'hDEAD, 32'h500);
    expect_redirect("mtc0_vs_int", 1'b1, HANDLER, 1'b1);
    step();
    rd(A_EPC);   expect_out("mtc0_vs_int_epc", K_RDATA, 32'h500);   step();
    rd(A_CAUSE); expect_out("mtc0_vs_int_cause", K_RDATA, 32'h400); step();

    // Bubble with sys raised
    drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0, 32'h600);
    expect_redirect("bubble_sys", 1'b0, 32'h0, 1'b0);
    step();
    rd(A_EPC); expect_out("bubble_sys_epc", K_RDATA, 32'h500); step();

    // Quiesce: clear IP[10], IM=0, IE=1, EXL=0
    drive(1'b1, 1'b1, 1'b0, 1'b0, A_CAUSE, 32'h400, 32'h180); irq = 3'b000;
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b0, A_STATUS, 32'h1, 32'h184);
    step();
    rd(A_STATUS); expect_out("st1", K_RDATA, 32'h1);
    expect_out("st1_ie", K_IE, 32'h1);
    expect_out("st1_exl", K_EXL, 32'h0);
    step();

    // Timer: Compare=5, Count=0, IP[7] visible at Count=6
    drive(1'b1, 1'b1, 1'b0, 1'b0, A_COMPARE, 32'h5, 32'h190); step();
    drive(1'b1, 1'b1, 1'b0, 1'b0, A_COUNT, 32'h0, 32'h194);    step();
    for (int k = 0; k < 6; k++) begin
      rd(A_COUNT);
      expect_out($sformatf("count_%0d", k), K_RDATA, k);
      step();
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, A_CAUSE, 32'h0, 32'h800);
    expect_out("timer_ip7", K_RDATA, 32'h80);
    expect_redirect("timer_masked", 1'b0, 32'h0, 1'b0);
    step();
    rd(A_COUNT); expect_out("count_7", K_RDATA, 32'h7); step();
    drive(1'b1, 1'b1, 1'b0, 1'b0, A_COMPARE, 32'h100, 32'h804); step();
    rd(A_CAUSE);   expect_out("cmp_clr_ip7", K_RDATA, 32'h0);   step();
    rd(A_COMPARE); expect_out("compare_rb", K_RDATA, 32'h100);  step();

    // Same-cycle IP set and W1C: set wins
    drive(1'b1, 1'b1, 1'b0, 1'b0, A_CAUSE, 32'h100, 32'h808); irq = 3'b001;
    step();
    rd(A_CAUSE); expect_out("set_wins", K_RDATA, 32'h100); step();

    // Enter handler, then reset mid-handler
    drive(1'b1, 1'b1, 1'b0, 1'b0, A_STATUS, 32'h101, 32'h80C); step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h700);
    expect_redirect("irq0_take", 1'b1, HANDLER, 1'b1);
    step();
    rd(A_STATUS); expect_out("h_status", K_RDATA, 32'h103);
    expect_out("h_exl", K_EXL, 32'h1);
    step();
    rst_n = 1'b0; irq = 3'b000;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0, 32'h704);
    expect_redirect("midrst", 1'b0, 32'h0, 1'b0);
    step();
    rst_n = 1'b1;
    rd(A_STATUS); expect_out("post_status", K_RDATA, 32'h0);
    expect_out("post_exl", K_EXL, 32'h0);
    expect_out("post_ie", K_IE, 32'h0);
    expect_redirect("post_idle", 1'b0, 32'h0, 1'b0);
    step();
    rd(A_CAUSE);   expect_out("post_cause", K_RDATA, 32'h0);   step();
    rd(A_EPC);     expect_out("post_epc", K_RDATA, 32'h0);     step();
    rd(A_COMPARE); expect_out("post_compare", K_RDATA, 32'h0); step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule : tb_cp0_unit

`default_nettype wire

// File: doc/cp0_unit.md
# cp0_unit

Coprocessor-0 responder for the single-cycle MIPS core. Consumes the `mfc0`, `mtc0`, `exce_ret` and `sys` strobes produced by instruction decode. Holds Status, Cause, EPC, Count and Compare. Arbitrates syscall, external/timer interrupts and ERET into a single same-cycle PC redirect for the fetch logic.

## Interface
- `HANDLER_ADDR`, default 32'h0000_0180: exception/interrupt vector.
- `clk` in 1: system clock; all state updates on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `inst_valid` in 1: current instruction is real, not a bubble; all strobes are ignored when 0.
- `mfc0`, `mtc0`, `exce_ret`, `sys` in 1: decode strobes.
- `cp0_addr` in 5: CP0 register number (rd field).
- `wdata` in 32: rt value for mtc0.
- `pc_cur` in 32: PC of the current instruction.
- `irq` in 3: external interrupt lines, synchronous to `clk`, level.
- `rdata` out 32: mfc0 read data.
- `redirect` out 1: fetch must load `redirect_pc` next.
- `redirect_pc` out 32: target address.
- `flush` out 1: suppress the current instruction's register/memory writes.
- `exl`, `ie` out 1: Status bits, for debug and hazard logic.

## Operation
- Registers, by number:
  - Count (9): 32-bit, +1 every cycle, wraps.
  - Compare (11).
  - Status (12): IM[10:7], EXL[1], IE[0]; other bits read 0.
  - Cause (13): IP[10:7], ExcCode[6:2]; other bits read 0.
  - EPC (14).
  - Any other address reads 0; writes to it are ignored.
- Interrupt sources:
  - Timer: IP[7] sets in the cycle Count==Compare and Compare!=0.
  - External: IP[8+n] sets on a rising edge of `irq[n]`, using a registered copy `irq_q`.
  - All IP bits are sticky.
- Per-cycle priority, evaluated only when `inst_valid`=1:
  1. `sys`: EPC<=pc_cur only if EXL=0. ExcCode<=8, EXL<=1, redirect to HANDLER_ADDR, flush=1.
  2. Interrupt: taken when IE=1, EXL=0 and (IP&IM)!=0. EPC<=pc_cur, ExcCode<=0, EXL<=1, redirect to HANDLER_ADDR, flush=1. The interrupted instruction re-executes after ERET.
  3. `exce_ret`: EXL<=0, redirect to the current EPC, flush=0.
  4. `mtc0`, with flush=0:
     - Status: IM, EXL and IE take the written bits.
     - Cause: write-1-to-clear, IP<=IP&~wdata[10:7]; ExcCode is not writable.
     - EPC: full write.
     - Count: loads wdata; the increment is suppressed that cycle.
     - Compare: loads wdata and clears IP[7].
- A lower-priority strobe arriving with a higher-priority event in the same cycle is dropped; a dropped mtc0 does not write.
- IP set and W1C clear in the same cycle: set wins.
- mfc0: `rdata` is combinational on `cp0_addr` and shows pre-edge state. It is driven regardless of the `mfc0` strobe; the write-back mux qualifies it.
- `irq` edge detection and Count run even when `inst_valid`=0. Interrupts are only taken when `inst_valid`=1, so EPC is always meaningful.

## Timing
- `redirect`, `redirect_pc` and `flush` are combinational from the current inputs and state. They are valid within the same cycle.
- Register updates are visible one cycle after the strobe edge.
- Interrupt latency:
  - External: IP sets 1 cycle after `irq` rises; the interrupt can be taken in that same following cycle.
  - Timer: IP[7] sets 1 cycle after the match.
- After ERET clears EXL, a pending interrupt is taken no earlier than the next valid instruction, which is the one at EPC.
- Reset (`rst_n`=0 at an edge): all registers and `irq_q` go to 0.
  - Outputs `redirect`=0, `flush`=0, `exl`=0, `ie`=0; `rdata` reads 0.
  - Reset dominates every strobe in that cycle. Reset mid-handler drops EXL and EPC.

## Structure
- Package `cp0_pkg`:
  - Register numbers CP0_COUNT=9, CP0_COMPARE=11, CP0_STATUS=12, CP0_CAUSE=13, CP0_EPC=14.
  - ExcCode constants EXC_INT=0, EXC_SYS=8.
  - Bit-position constants for IE, EXL and the IM/IP/ExcCode fields.
- Sub-module `cp0_timer`: Count/Compare registers, load ports and the match pulse. All other logic lives in `cp0_unit`.

## Test plan
- Syscall: reset, then Status=0; sys at pc_cur=0x40 → redirect=1, redirect_pc=0x180, flush=1. Next cycle EPC=0x40, Cause=0x20, Status=0x2.
- Interrupt enable: mtc0 Status=0x401 (IM[10], IE); raise irq[2] → IP[10] set next cycle; instruction at pc_cur=0x88 redirected to 0x180 with flush; EPC=0x88, EXL=1.
- ERET and re-entry: in the handler, mtc0 Cause=0x400 clears IP[10]; then eret → redirect_pc=0x88, EXL=0 next cycle, no re-entry. Repeat without clearing IP → interrupt retaken at 0x88 on the following valid cycle.
- Timer: Compare=5 after Count reset to 0 → IP[7]=1 at Count=6. IM[7]=0 → no redirect. mtc0 Compare clears IP[7].
- Collisions:
  - sys with a pending enabled interrupt → ExcCode=8.
  - mtc0 EPC with an interrupt → EPC=pc_cur, not wdata.
  - sys with EXL=1 → EPC unchanged.
  - `inst_valid`=0 with sys=1 → no redirect.
- Mid-handler reset: rst_n low for one edge with EXL=1 → all registers 0, redirect=0.
